resv_sched_pip2: RTL and testbench
==================================

Name: resv_sched_pip2

Overview:
- Controller for one 8-cell two-bank reservation station built from shift-compacting cells.
- Cell 0 holds the oldest entry. Removing cell k shifts cells k..7 down by one.
- Tracks occupancy and accepts decoder inserts at the tail. Each cycle it picks at most one ready entry for either issue port (bank0 or bank1) and drives the cells' addr_insert, addr_shift and clear inputs.
- Sits between the decoder, the cell array and the two execution pipes.

Parameters:
- N_CELL, 8, number of cells. The fixed 8-cell slice scheme allows only 8.
- W_ident, 4, cell index width. The all-ones code means "no cell".
- W_cnt, 4, occupancy counter width; holds 0..N_CELL.
- unused_cd, {W_ident{1'b1}}, null index driven on addr buses.

Ports:
- clk  in  1  clock
- clear_n  in  1  asynchronous active-low reset
- cand0_bus  in  N_CELL*W_ident  bank0 candidate codes, cell i at slice [i*W_ident +: W_ident]
- cand1_bus  in  N_CELL*W_ident  bank1 candidate codes, same packing
- dec_valid  in  1  decoder has an entry to insert
- dec_ready  out  1  insert accepted this cycle
- iss0_ready  in  1  bank0 pipe can take an entry
- iss0_valid  out  1  bank0 issue grant (fire)
- iss1_ready  in  1  bank1 pipe can take an entry
- iss1_valid  out  1  bank1 issue grant (fire)
- iss_sel  out  W_ident  index of the granted cell (data mux select); unused_cd when no grant
- addr_shift  out  W_ident  to all cells
- addr_insert  out  W_ident  to all cells
- cell_clear  out  1  to all cells' clear input
- flush  in  1  squash all entries
- occ  out  W_cnt  current occupancy
- stat_issue_cnt  out  32  see Optional Feature
- stat_full_cnt  out  32  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. Reset clear_n is asynchronous and active-low.
- Reset values: state=INIT, occ=0, rr=0, cell_clear=1, dec_ready=0, iss0_valid=0, iss1_valid=0, iss_sel=unused_cd, addr_shift=unused_cd, addr_insert=unused_cd, stats=0.
- Reset asserted mid-operation discards everything and returns to INIT.
- States:
  - INIT drives cell_clear=1 for exactly one cycle, then goes to EMPTY.
  - EMPTY (occ=0), ACTIVE (0<occ<8) and FULL (occ=8) are selected from next occ.
  - FLUSH is entered from any run state when flush=1. It drives cell_clear=1 for one cycle, then goes to EMPTY.
- In INIT and FLUSH: dec_ready=0, no grants, address buses at unused_cd.
- flush=1 in a run state overrides that cycle's issue and insert: no fire, and occ becomes 0 at the edge.
- Candidate selection, per bank b: found_b = any slice of candb_bus not equal to unused_cd. idx_b = lowest such slice index (oldest entry). Slices with i >= occ are ignored.
- Eligibility: elig_b = found_b & issb_ready. Valid depends combinationally on ready.
- Arbitration, one grant per cycle:
  - Only one bank eligible: grant it.
  - Both eligible: grant bank rr, then toggle rr at the edge.
  - rr does not change on single-eligible cycles.
- issue_fire = iss0_valid | iss1_valid. On fire, iss_sel = addr_shift = granted idx; otherwise both are unused_cd.
- dec_ready = run state & (occ<N_CELL | issue_fire).
- dec_fire = dec_valid & dec_ready. addr_insert = occ - issue_fire when dec_fire, else unused_cd.
- Simultaneous issue and insert: insert lands at occ-1. Cell-side insert priority makes this correct.
- occ_next = occ + dec_fire - issue_fire. No wrap: occ never exceeds N_CELL and never goes below 0.
- Full with no issue: dec_ready=0, occ holds at 8.
- Latency: grant and shift take effect at the same edge. An inserted entry is a candidate no earlier than the next cycle.

Optional Feature:
- Macro: RESV_SCHED_STATS_EN.
- Defined:
  - stat_issue_cnt increments on each issue_fire.
  - stat_full_cnt increments on each cycle with state=FULL & dec_valid & !dec_ready.
  - Both are 32-bit, wrap at 2^32, cleared only by reset (not by flush).
- Undefined: no counter registers; both outputs tied to 0.

Test Plan:
- Reset release -> cell_clear=1 for one cycle, then EMPTY, occ=0, dec_ready=1.
- Insert 3 entries back-to-back -> addr_insert=0,1,2 on successive cycles; occ=3.
- Cells 1 and 2 candidates on bank0, cell 2 on bank1, iss0_ready=1, iss1_ready=0 -> iss0_valid=1, iss_sel=1, addr_shift=1; occ 3->2.
- Both banks eligible two consecutive cycles, rr=0 -> grants bank0 then bank1.
- occ=8, dec_valid=1, no candidate -> dec_ready=0 and occ holds. With candidate at cell 4 and grant -> dec_ready=1, addr_shift=4, addr_insert=7, occ stays 8.
- flush with dec_valid=1 and a grant pending -> no fire, FLUSH cycle with cell_clear=1, then occ=0. With RESV_SCHED_STATS_EN, counters are unchanged by the flush.

Source files
------------

// File: rtl/resv_sched_pip2.sv
// rtl/resv_sched_pip2.sv - scheduler for an 8-cell two-bank shift-compacting reservation station
//
// Purpose:
//   Tracks occupancy of the cell array, accepts decoder inserts at the tail,
//   grants at most one ready entry per cycle to either issue bank and drives
//   the cells' addr_insert / addr_shift / clear controls.
//   Cell 0 is the oldest entry; removing cell k shifts cells k..7 down by one.
//
// Ports:
//   clk, clear_n              clock, asynchronous active-low reset
//   cand0_bus, cand1_bus      per-cell candidate codes per bank (unused_cd = not ready)
//   dec_valid / dec_ready     decoder insert handshake
//   iss0_ready / iss0_valid   bank0 pipe handshake (valid is the grant)
//   iss1_ready / iss1_valid   bank1 pipe handshake
//   iss_sel                   granted cell index, unused_cd when idle
//   addr_shift, addr_insert   cell array controls, unused_cd when idle
//   cell_clear                clears every cell (INIT and FLUSH)
//   flush                     squash all entries
//   occ                       current occupancy
//   stat_issue_cnt/full_cnt   statistics counters
//
// Configuration:
//   RESV_SCHED_STATS_EN       when defined, builds the two statistics counters;
//                             otherwise both stat outputs are tied to zero.

module resv_sched_pip2 #(
   parameter int                 N_CELL    = 8,
   parameter int                 W_ident   = 4,
   parameter int                 W_cnt     = 4,
   parameter logic [W_ident-1:0] unused_cd = {W_ident{1'b1}}
) (
   input  logic                      clk,
   input  logic                      clear_n,
   input  logic [N_CELL*W_ident-1:0] cand0_bus,
   input  logic [N_CELL*W_ident-1:0] cand1_bus,
   input  logic                      dec_valid,
   output logic                      dec_ready,
   input  logic                      iss0_ready,
   output logic                      iss0_valid,
   input  logic                      iss1_ready,
   output logic                      iss1_valid,
   output logic [W_ident-1:0]        iss_sel,
   output logic [W_ident-1:0]        addr_shift,
   output logic [W_ident-1:0]        addr_insert,
   output logic                      cell_clear,
   input  logic                      flush,
   output logic [W_cnt-1:0]          occ,
   output logic [31:0]               stat_issue_cnt,
   output logic [31:0]               stat_full_cnt
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_EMPTY  = 3'd1,
      S_ACTIVE = 3'd2,
      S_FULL   = 3'd3,
      S_FLUSH  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [W_cnt-1:0]   occ_q, occ_d;
   logic               rr_q, rr_d;

   logic               run_st;
   logic               go;
   logic               found0, found1;
   logic [W_ident-1:0] idx0, idx1;
   logic               elig0, elig1;
   logic               grant0, grant1;
   logic               issue_fire;
   logic               dec_fire;
   logic [W_ident-1:0] sel;

   always_comb begin
      run_st = (state_q == S_EMPTY) || (state_q == S_ACTIVE) || (state_q == S_FULL);
      // flush in a run state suppresses both issue and insert for this cycle
      go     = run_st & ~flush;

      // Scan from the top down so the lowest (oldest) valid slice wins.
      // Slices at or above occ hold stale data and are ignored.
      found0 = 1'b0;
      found1 = 1'b0;
      idx0   = unused_cd;
      idx1   = unused_cd;
      for (int i = N_CELL - 1; i >= 0; i--) begin
         if ((W_cnt'(i) < occ_q) && (cand0_bus[i*W_ident +: W_ident] != unused_cd)) begin
            found0 = 1'b1;
            idx0   = W_ident'(i);
         end
         if ((W_cnt'(i) < occ_q) && (cand1_bus[i*W_ident +: W_ident] != unused_cd)) begin
            found1 = 1'b1;
            idx1   = W_ident'(i);
         end
      end

      elig0  = go & found0 & iss0_ready;
      elig1  = go & found1 & iss1_ready;
      // rr only breaks ties; a lone eligible bank always wins
      grant0 = elig0 & (~elig1 | ~rr_q);
      grant1 = elig1 & (~elig0 |  rr_q);
      issue_fire = grant0 | grant1;

      if (grant0)      sel = idx0;
      else if (grant1) sel = idx1;
      else             sel = unused_cd;

      // A full station can still accept when an issue frees a cell this cycle
      dec_ready = go & ((occ_q < W_cnt'(N_CELL)) | issue_fire);
      dec_fire  = dec_valid & dec_ready;

      // With a concurrent issue the tail moves down one; the cells give
      // insert priority over shift, so landing at occ-1 is correct.
      if (dec_fire) addr_insert = W_ident'(occ_q - W_cnt'(issue_fire));
      else          addr_insert = unused_cd;

      occ_d   = occ_q + W_cnt'(dec_fire) - W_cnt'(issue_fire);
      rr_d    = (elig0 & elig1) ? ~rr_q : rr_q;
      state_d = state_q;

      case (state_q)
         S_INIT, S_FLUSH: begin
            occ_d   = '0;
            rr_d    = rr_q;
            state_d = S_EMPTY;
         end
         default: begin
            if (flush) begin
               occ_d   = '0;
               state_d = S_FLUSH;
            end else if (occ_d == '0) begin
               state_d = S_EMPTY;
            end else if (occ_d == W_cnt'(N_CELL)) begin
               state_d = S_FULL;
            end else begin
               state_d = S_ACTIVE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_INIT;
         occ_q   <= '0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         rr_q    <= rr_d;
      end
   end

   assign iss0_valid = grant0;
   assign iss1_valid = grant1;
   assign iss_sel    = sel;
   assign addr_shift = sel;
   // cell_clear comes straight from the state register
   assign cell_clear = (state_q == S_INIT) || (state_q == S_FLUSH);
   assign occ        = occ_q;

`ifdef RESV_SCHED_STATS_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] full_cnt_q,  full_cnt_d;
   logic        full_evt;

   always_comb begin
      // a flush cycle is not counted as backpressure
      full_evt    = (state_q == S_FULL) & dec_valid & ~dec_ready & ~flush;
      issue_cnt_d = issue_cnt_q + 32'(issue_fire);
      full_cnt_d  = full_cnt_q + 32'(full_evt);
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         issue_cnt_q <= '0;
         full_cnt_q  <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         full_cnt_q  <= full_cnt_d;
      end
   end

   assign stat_issue_cnt = issue_cnt_q;
   assign stat_full_cnt  = full_cnt_q;
`else
   assign stat_issue_cnt = 32'd0;
   assign stat_full_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_resv_sched_pip2.sv
// tb/tb_resv_sched_pip2.sv - self-checking bench for resv_sched_pip2
module tb_resv_sched_pip2;

   logic        clk = 1'b0;
   logic        clear_n;
   logic [31:0] cand0_bus, cand1_bus;
   logic        dec_valid, dec_ready;
   logic        iss0_ready, iss0_valid;
   logic        iss1_ready, iss1_valid;
   logic [3:0]  iss_sel, addr_shift, addr_insert;
   logic        cell_clear;
   logic        flush;
   logic [3:0]  occ;
   logic [31:0] stat_issue_cnt, stat_full_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   resv_sched_pip2 dut (
      .clk(clk), .clear_n(clear_n),
      .cand0_bus(cand0_bus), .cand1_bus(cand1_bus),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .iss0_ready(iss0_ready), .iss0_valid(iss0_valid),
      .iss1_ready(iss1_ready), .iss1_valid(iss1_valid),
      .iss_sel(iss_sel), .addr_shift(addr_shift), .addr_insert(addr_insert),
      .cell_clear(cell_clear), .flush(flush), .occ(occ),
      .stat_issue_cnt(stat_issue_cnt), .stat_full_cnt(stat_full_cnt)
   );

   // ---------------- reference model ----------------
   // phase: 0 = clearing (INIT/FLUSH cycle), 1 = running, 2 = flush cycle
   int m_phase, m_occ, m_rr;
   longint m_iss_cnt, m_full_cnt;
   int e_ready, e_v0, e_v1, e_sel, e_ins, e_clr, e_both;

   task automatic model_eval();
      int oldest0, oldest1, el0, el1, run;
      run = (m_phase == 1) && !flush;
      oldest0 = -1; oldest1 = -1;
      for (int i = 0; i < m_occ; i++) begin
         if (oldest0 < 0 && cand0_bus[i*4 +: 4] != 4'hF) oldest0 = i;
         if (oldest1 < 0 && cand1_bus[i*4 +: 4] != 4'hF) oldest1 = i;
      end
      el0 = run && oldest0 >= 0 && iss0_ready;
      el1 = run && oldest1 >= 0 && iss1_ready;
      e_both = el0 && el1;
      e_v0 = 0; e_v1 = 0;
      if (e_both) begin
         if (m_rr == 0) e_v0 = 1; else e_v1 = 1;
      end else begin
         e_v0 = el0; e_v1 = el1;
      end
      e_sel   = e_v0 ? oldest0 : (e_v1 ? oldest1 : 15);
      e_ready = run && (m_occ < 8 || e_v0 || e_v1);
      e_ins   = (dec_valid && e_ready) ? m_occ - (e_v0 + e_v1) : 15;
      e_clr   = (m_phase != 1);
   endtask

   task automatic model_commit();
      if (m_phase != 1) begin
         m_phase = 1; m_occ = 0;
      end else if (flush) begin
         m_phase = 2; m_occ = 0;
      end else begin
`ifdef RESV_SCHED_STATS_EN
         m_iss_cnt += e_v0 + e_v1;
         if (m_occ == 8 && dec_valid && !e_ready) m_full_cnt++;
`endif
         m_occ = m_occ + (dec_valid && e_ready) - (e_v0 + e_v1);
         if (e_both) m_rr = 1 - m_rr;
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_occ = 0; m_rr = 0; m_iss_cnt = 0; m_full_cnt = 0;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("dec_ready", dec_ready, e_ready);
      chk("iss0_valid", iss0_valid, e_v0);
      chk("iss1_valid", iss1_valid, e_v1);
      chk("iss_sel", iss_sel, e_sel);
      chk("addr_shift", addr_shift, e_sel);
      chk("addr_insert", addr_insert, e_ins);
      chk("cell_clear", cell_clear, e_clr);
      chk("occ", occ, m_occ);
      chk("stat_issue", stat_issue_cnt, m_iss_cnt);
      chk("stat_full", stat_full_cnt, m_full_cnt);
   endtask

   function automatic logic [31:0] mask_bus(input logic [7:0] m);
      logic [31:0] b;
      for (int i = 0; i < 8; i++) b[i*4 +: 4] = m[i] ? 4'h0 : 4'hF;
      return b;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       dv, r0, r1, fl;
      logic [7:0] m0, m1;
      int         rdy, v0, v1, sel, ins, clr, occ;
   } vec_t;

   vec_t tv[20];

   initial begin
      tv[0]  = '{1,0,0,0, 8'h00, 8'h00,   0,0,0,15,15,1,0};
      tv[1]  = '{1,0,0,0, 8'h00, 8'h00,   1,0,0,15, 0,0,0};
      tv[2]  = '{1,0,0,0, 8'h00, 8'h00,   1,0,0,15, 1,0,1};
      tv[3]  = '{1,0,0,0, 8'h00, 8'h00,   1,0,0,15, 2,0,2};
      tv[4]  = '{0,1,0,0, 8'h06, 8'h04,   1,1,0, 1,15,0,3};
      tv[5]  = '{0,1,1,0, 8'h01, 8'h02,   1,1,0, 0,15,0,2};
      tv[6]  = '{0,1,1,0, 8'h01, 8'h01,   1,0,1, 0,15,0,1};
      for (int k = 0; k < 8; k++)
         tv[7+k] = '{1,0,0,0, 8'h00, 8'h00, 1,0,0,15, k,0,k};
      tv[15] = '{1,1,1,0, 8'h00, 8'h00,   0,0,0,15,15,0,8};
      tv[16] = '{1,1,0,0, 8'h10, 8'h00,   1,1,0, 4, 7,0,8};
      tv[17] = '{1,1,1,1, 8'hFF, 8'hFF,   0,0,0,15,15,0,8};
      tv[18] = '{1,1,1,0, 8'hFF, 8'hFF,   0,0,0,15,15,1,0};
      tv[19] = '{0,0,0,0, 8'h00, 8'h00,   1,0,0,15,15,0,0};

      clear_n = 1'b0; dec_valid = 0; iss0_ready = 0; iss1_ready = 0; flush = 0;
      cand0_bus = '1; cand1_bus = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst cell_clear", cell_clear, 1);
      chk("rst dec_ready", dec_ready, 0);
      chk("rst occ", occ, 0);
      chk("rst iss_sel", iss_sel, 15);
      chk("rst addr_insert", addr_insert, 15);
      chk("rst addr_shift", addr_shift, 15);
      chk("rst stat_issue", stat_issue_cnt, 0);
      clear_n = 1'b1;

      for (int v = 0; v < 20; v++) begin
         dec_valid = tv[v].dv; iss0_ready = tv[v].r0; iss1_ready = tv[v].r1;
         flush = tv[v].fl;
         cand0_bus = mask_bus(tv[v].m0); cand1_bus = mask_bus(tv[v].m1);
         model_eval();
         @(negedge clk);
         chk($sformatf("v%0d dec_ready", v), dec_ready, tv[v].rdy);
         chk($sformatf("v%0d iss0_valid", v), iss0_valid, tv[v].v0);
         chk($sformatf("v%0d iss1_valid", v), iss1_valid, tv[v].v1);
         chk($sformatf("v%0d iss_sel", v), iss_sel, tv[v].sel);
         chk($sformatf("v%0d addr_shift", v), addr_shift, tv[v].sel);
         chk($sformatf("v%0d addr_insert", v), addr_insert, tv[v].ins);
         chk($sformatf("v%0d cell_clear", v), cell_clear, tv[v].clr);
         chk($sformatf("v%0d occ", v), occ, tv[v].occ);
         chk($sformatf("v%0d stat_issue", v), stat_issue_cnt, m_iss_cnt);
         chk($sformatf("v%0d stat_full", v), stat_full_cnt, m_full_cnt);
         @(posedge clk);
         model_commit();
         #1;
      end

      // ---------------- randomized run vs model ----------------
      for (int c = 0; c < 1500; c++) begin
         dec_valid  = ($urandom % 4) != 0;
         iss0_ready = ($urandom % 10) < 6;
         iss1_ready = ($urandom % 10) < 6;
         flush      = ($urandom % 60) == 0;
         for (int i = 0; i < 8; i++) begin
            cand0_bus[i*4 +: 4] = ($urandom % 3 == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            cand1_bus[i*4 +: 4] = ($urandom % 3 == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
         end
         model_eval();
         @(negedge clk);
         chk_model();
         @(posedge clk);
         model_commit();
         #1;
      end

      // ---------------- asynchronous reset mid-operation ----------------
      dec_valid = 1; iss0_ready = 0; iss1_ready = 0; flush = 0;
      repeat (3) @(posedge clk);
      #2;
      clear_n = 1'b0;
      #1;
      chk("arst occ", occ, 0);
      chk("arst cell_clear", cell_clear, 1);
      chk("arst dec_ready", dec_ready, 0);
      chk("arst stat_issue", stat_issue_cnt, 0);
      chk("arst stat_full", stat_full_cnt, 0);
      model_reset();
      @(posedge clk);
      #1;
      clear_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         model_eval();
         @(negedge clk);
         chk_model();
         @(posedge clk);
         model_commit();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
